// File: rtl/imem_loader.sv
// imem_loader: streams a program image into the dual-issue instruction memory.
// The image is a 4-byte little-endian word count N followed by N little-endian
// 32-bit words. Words are written in pairs, and the core is held in reset
// until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, the
// image is followed by one XOR checksum byte that covers the header and data.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             begin a load (honoured in IDLE, DONE, ERR)
//   i_in_data/i_in_valid, o_in_ready   byte stream handshake
//   o_wr_en, o_wr_addr, o_wr_data1, o_wr_data2   instruction pair write port
//   o_core_rst, o_busy, o_done, o_err            status levels
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] PAD_WORD  = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data1,
    output logic [31:0] o_wr_data2,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd6;
    // State reached once the last word is written (or N = 0)
    localparam logic [2:0] S_FINAL = S_CSUM;
`else
    localparam logic [2:0] S_FINAL = S_DONE;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_state_nx;
    logic [2:0]  r_byte_cnt;
    logic [23:0] r_hdr;
    logic [31:0] r_words_left;
    logic        w_xfer;
    logic [31:0] w_n;
    logic        w_last_odd;
    logic        w_pair_done;
    logic [4:0]  w_lane;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    // in_ready is registered from the next state, so it already reflects r_state
    assign w_xfer      = i_in_valid & o_in_ready;
    // Header is shifted in from the top: the 4th byte completes N
    assign w_n         = {i_in_data, r_hdr};
    // Final word of an odd count closes the pair after only 4 bytes
    assign w_last_odd  = (r_words_left == 32'd1) && (r_byte_cnt == 3'd3);
    assign w_pair_done = (r_byte_cnt == 3'd7) || w_last_odd;
    assign w_lane      = {r_byte_cnt[1:0], 3'b000};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) w_state_nx = S_HDR;
            end
            S_HDR: begin
                if (w_xfer && (r_byte_cnt == 3'd3)) begin
                    if (w_n > 32'(MAX_WORDS)) w_state_nx = S_ERR;
                    else if (w_n == 32'd0)    w_state_nx = S_FINAL;
                    else                      w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && w_pair_done) w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                w_state_nx = (r_words_left == 32'd0) ? S_FINAL : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) w_state_nx = (i_in_data == r_csum) ? S_DONE : S_ERR;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_in_ready <= 1'b0;
            o_wr_en    <= 1'b0;
            o_core_rst <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            o_in_ready <= (w_state_nx == S_HDR) || (w_state_nx == S_DATA) || (w_state_nx == S_CSUM);
            o_busy     <= (w_state_nx == S_HDR) || (w_state_nx == S_DATA) ||
                          (w_state_nx == S_WRITE) || (w_state_nx == S_CSUM);
`else
            o_in_ready <= (w_state_nx == S_HDR) || (w_state_nx == S_DATA);
            o_busy     <= (w_state_nx == S_HDR) || (w_state_nx == S_DATA) || (w_state_nx == S_WRITE);
`endif
            o_wr_en    <= (w_state_nx == S_WRITE);
            o_core_rst <= (w_state_nx != S_DONE);
            o_done     <= (w_state_nx == S_DONE);
            o_err      <= (w_state_nx == S_ERR);
        end
    end

    // Header capture, word assembly, address and checksum tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt   <= 3'd0;
            r_hdr        <= 24'd0;
            r_words_left <= 32'd0;
            o_wr_addr    <= BASE_ADDR;
            o_wr_data1   <= 32'd0;
            o_wr_data2   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        r_byte_cnt   <= 3'd0;
                        r_hdr        <= 24'd0;
                        r_words_left <= 32'd0;
                        o_wr_addr    <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum       <= 8'd0;
`endif
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_hdr <= {i_in_data, r_hdr[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ i_in_data;
`endif
                        if (r_byte_cnt == 3'd3) begin
                            r_byte_cnt   <= 3'd0;
                            r_words_left <= w_n;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        if (r_byte_cnt[2]) o_wr_data2[w_lane +: 8] <= i_in_data;
                        else               o_wr_data1[w_lane +: 8] <= i_in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ i_in_data;
`endif
                        if (w_pair_done) begin
                            r_byte_cnt <= 3'd0;
                            if (w_last_odd) begin
                                o_wr_data2   <= PAD_WORD;
                                r_words_left <= r_words_left - 32'd1;
                            end else begin
                                r_words_left <= r_words_left - 32'd2;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    o_wr_addr <= o_wr_addr + 32'd8;
                end
                default: ;
            endcase
        end
    end

endmodule
